// File: rtl/demux_destino.sv
// -----------------------------------------------------------------------------
// demux_destino
//
// Receive side of the transaction-layer arbitration path. Drains the shared
// FIFO filled by the priority arbiter, decodes the destination field held in
// the two MSBs of each word and pushes the word into exactly one of the four
// purple (morado) output FIFOs, honouring that FIFO's almost_full.
//
// A word moves through three phases:
//   IDLE    : pop the shared FIFO when the path is active and it has data
//   WAIT_RD : the shared FIFO presents the word one cycle after the pop;
//             capture it
//   SEND    : push it to its destination once that FIFO can accept it; if
//             more data is waiting, pop the next word in the same cycle so
//             an unblocked stream runs at one word every two cycles
//
// Ports
//   clk            system clock, rising edge
//   reset_L        asynchronous active-low reset
//   state          top-level FSM state; 4'b0001 (INIT) clears this block
//                  synchronously and holds it idle
//   data_in        shared FIFO read data, valid the cycle after pop_in
//   empty_in       shared FIFO empty
//   almost_full0-3 backpressure from purple FIFO n
//   pop_in         pop request to the shared FIFO
//   push0-3        push strobe to purple FIFO n (at most one high per cycle)
//   data_out       write data shared by all purple FIFOs
//   cnt0-3         words delivered to purple FIFO n (wraps silently)
//   idle           no word in flight and shared FIFO empty
// -----------------------------------------------------------------------------
module demux_destino #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              empty_in,
  input  logic              almost_full0,
  input  logic              almost_full1,
  input  logic              almost_full2,
  input  logic              almost_full3,
  output logic              pop_in,
  output logic              push0,
  output logic              push1,
  output logic              push2,
  output logic              push3,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic [CNT_W-1:0]  cnt3,
  output logic              idle
);

  localparam logic [3:0] STATE_INIT = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT_RD = 2'b01,
    ST_SEND    = 2'b10
  } fsm_t;

  // Destination code to one-hot push vector.
  function automatic logic [3:0] dest_onehot(input logic [1:0] dest);
    logic [3:0] vec;
    case (dest)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

  fsm_t              fsm_r;
  // The held word doubles as data_out: it is loaded only on capture, so the
  // purple FIFOs see a stable value that only moves when a new word arrives.
  logic [DATA_W-1:0] hold_r;
  logic [CNT_W-1:0]  cnt_r [4];

  logic              active_s;
  logic [3:0]        af_vec_s;
  logic [1:0]        dest_s;
  logic              send_ok_s;
  logic              pop_s;
  logic [3:0]        push_vec_s;

  assign active_s = (state != STATE_INIT);
  assign af_vec_s = {almost_full3, almost_full2, almost_full1, almost_full0};
  assign dest_s   = hold_r[DATA_W-1 -: 2];

  // Only the addressed FIFO's almost_full matters; a blocked word stalls the
  // whole path (no bypass to other destinations).
  assign send_ok_s = active_s & (fsm_r == ST_SEND) & ~af_vec_s[dest_s];

  // Pop request: from IDLE when data is waiting, or chained from a
  // successful SEND so the next word is read while this one is written.
  // Gated by reset_L so nothing is popped while the block is held in reset.
  always_comb begin
    pop_s = 1'b0;
    case (fsm_r)
      ST_IDLE:    pop_s = active_s & ~empty_in;
      ST_WAIT_RD: pop_s = 1'b0;
      ST_SEND:    pop_s = send_ok_s & ~empty_in;
      default:    pop_s = 1'b0;
    endcase
    if (!reset_L) begin
      pop_s = 1'b0;
    end else begin
      pop_s = pop_s;
    end
  end

  // One-hot push strobe for the decoded destination.
  always_comb begin
    if (send_ok_s) begin
      push_vec_s = dest_onehot(dest_s);
    end else begin
      push_vec_s = 4'b0000;
    end
  end

  // Transfer FSM and word capture; INIT returns to IDLE, dropping any word
  // in flight (the shared FIFO has already advanced past it).
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_r  <= ST_IDLE;
      hold_r <= '0;
    end else if (!active_s) begin
      fsm_r  <= ST_IDLE;
      hold_r <= hold_r;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (pop_s) begin
            fsm_r <= ST_WAIT_RD;
          end else begin
            fsm_r <= ST_IDLE;
          end
        end
        ST_WAIT_RD: begin
          hold_r <= data_in;
          fsm_r  <= ST_SEND;
        end
        ST_SEND: begin
          if (send_ok_s && !empty_in) begin
            fsm_r <= ST_WAIT_RD;
          end else if (send_ok_s) begin
            fsm_r <= ST_IDLE;
          end else begin
            fsm_r <= ST_SEND;
          end
        end
        default: begin
          fsm_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-destination delivery counters; they wrap without any flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (!active_s) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_vec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pop_in   = pop_s;
  assign push0    = push_vec_s[0];
  assign push1    = push_vec_s[1];
  assign push2    = push_vec_s[2];
  assign push3    = push_vec_s[3];
  assign data_out = hold_r;
  assign cnt0     = cnt_r[0];
  assign cnt1     = cnt_r[1];
  assign cnt2     = cnt_r[2];
  assign cnt3     = cnt_r[3];
  assign idle     = (fsm_r == ST_IDLE) & empty_in;

endmodule
